// File: rtl/rra_requester.sv
// rra_requester: client-side agent for the 4-way round-robin arbiter (rra).
// It accepts a job of job_len beats and raises req. It streams upstream beats
// onto the shared bus only while gnt is high. On grant loss it keeps req high
// and resumes where it stopped. It drops req once the last beat has gone out.
//
// Optional feature: define RRA_REQ_YIELD_EN to enable voluntary yield. After
// QUANTUM granted XFER cycles with beats still pending, req drops for exactly
// one cycle and the job then re-arbitrates. preempt_cnt is not incremented.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low (0 = reset)
//   job_valid    job offered
//   job_len      beats in the offered job (0 completes immediately)
//   job_ready    job accepted when job_valid && job_ready (IDLE only)
//   din_valid    upstream beat available
//   din          upstream beat data
//   din_ready    upstream beat consumed this cycle (combinational)
//   req          registered request to the arbiter
//   gnt          grant from the arbiter
//   bus_valid    registered beat strobe on the shared bus
//   bus_data     registered beat data; holds its value when idle
//   done         one-cycle job-complete pulse
//   preempt_cnt  saturating count of mid-job grant losses
//   err          sticky flag: grant seen while not requesting
module rra_requester #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int QUANTUM = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    input  logic [LEN_W-1:0]  job_len,
    output logic              job_ready,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              done,
    output logic [7:0]        preempt_cnt,
    output logic              err
);

`ifdef RRA_REQ_YIELD_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_GNT, S_XFER, S_RELEASE, S_YIELD
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT_GNT, S_XFER, S_RELEASE
    } state_t;
`endif

    state_t             state, state_nx;
    logic [LEN_W-1:0]   remaining, remaining_nx;
    logic               req_nx;
    logic               done_nx;
    logic [7:0]         preempt_nx;
    logic               was_release;
    logic               beat;
    logic               last_beat;

`ifdef RRA_REQ_YIELD_EN
    localparam int unsigned GCNT_W = (QUANTUM > 1) ? $clog2(QUANTUM + 1) : 1;
    logic [GCNT_W-1:0]  gcnt;
    logic               yield_now;
`endif

    assign din_ready = ((state == S_WAIT_GNT) || (state == S_XFER)) && gnt &&
                       (remaining != '0);
    assign beat      = din_ready && din_valid;
    assign last_beat = beat && (remaining == LEN_W'(1));

`ifdef RRA_REQ_YIELD_EN
    // This cycle is the QUANTUM-th granted XFER cycle. A last beat completes
    // the job instead of yielding.
    assign yield_now = (state == S_XFER) && gnt && !last_beat &&
                       (gcnt == GCNT_W'(QUANTUM - 1));
`endif

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        req_nx       = req;
        done_nx      = 1'b0;
        preempt_nx   = preempt_cnt;
        job_ready    = 1'b0;

        if (beat) begin
            remaining_nx = remaining - 1'b1;
        end

        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    if (job_len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        remaining_nx = job_len;
                        req_nx       = 1'b1;
                        state_nx     = S_WAIT_GNT;
                    end
                end
            end
            S_WAIT_GNT: begin
                // The first granted cycle may already carry the final beat of
                // a one-beat remainder.
                if (last_beat) begin
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_RELEASE;
                end else if (gnt) begin
                    state_nx = S_XFER;
                end
            end
            S_XFER: begin
                if (last_beat) begin
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_RELEASE;
                end else if (!gnt) begin
                    if (preempt_cnt != 8'hFF) begin
                        preempt_nx = preempt_cnt + 8'd1;
                    end
                    state_nx = S_WAIT_GNT;
`ifdef RRA_REQ_YIELD_EN
                end else if (yield_now) begin
                    req_nx   = 1'b0;
                    state_nx = S_YIELD;
`endif
                end
            end
            S_RELEASE: begin
                state_nx = S_IDLE;
            end
`ifdef RRA_REQ_YIELD_EN
            S_YIELD: begin
                req_nx   = 1'b1;
                state_nx = S_WAIT_GNT;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            req         <= 1'b0;
            done        <= 1'b0;
            preempt_cnt <= '0;
            bus_valid   <= 1'b0;
            bus_data    <= '0;
            was_release <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            remaining   <= remaining_nx;
            req         <= req_nx;
            done        <= done_nx;
            preempt_cnt <= preempt_nx;
            bus_valid   <= beat;
            if (beat) begin
                bus_data <= din;
            end
            // req is registered, so the arbiter may still grant during
            // RELEASE and the IDLE cycle right after it. That grant is legal.
            was_release <= (state == S_RELEASE);
            if (gnt && (state == S_IDLE) && !was_release) begin
                err <= 1'b1;
            end
        end
    end

`ifdef RRA_REQ_YIELD_EN
    // XFER is only ever entered from WAIT_GNT, so clearing outside XFER
    // restarts the count on every new grant period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt <= '0;
        end else if (state != S_XFER) begin
            gcnt <= '0;
        end else if (gnt) begin
            gcnt <= gcnt + 1'b1;
        end
    end
`endif

endmodule
